// File: rtl/branch_sequencer.sv
// Control sequencer for a conditional branch (T3..T6).
// It evaluates the branch condition, steps the PC datapath and counts the branches that are taken.
module branch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stall,
    input  logic [1:0]       ir_c2,
    input  logic [31:0]      bus_contents,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             zlow_out,
    output logic             pc_in,
    output logic             con_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    function automatic logic eval_cond(input logic [1:0] c2, input logic [31:0] value);
        logic result;
        case (c2)
            2'b00:   result = (value == 32'd0);
            2'b01:   result = (value != 32'd0);
            2'b10:   result = ~value[31];
            2'b11:   result = value[31];
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Sequencer state, condition flag and saturating taken-branch counter
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= S_IDLE;
            con_q       <= 1'b0;
            taken_count <= {CNT_W{1'b0}};
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_T3;
                    end
                end
                S_T3: begin
                    if (!stall) begin
                        state <= S_T4;
                        con_q <= eval_cond(ir_c2, bus_contents);
                    end
                end
                S_T4: begin
                    if (!stall) begin
                        state <= S_T5;
                    end
                end
                S_T5: begin
                    if (!stall) begin
                        state <= S_T6;
                    end
                end
                S_T6: begin
                    if (!stall) begin
                        state <= S_IDLE;
                        if (con_q && (taken_count != CNT_MAX)) begin
                            taken_count <= taken_count + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode the registered state; a stall suppresses them within the same cycle
    always_comb begin
        gra      = 1'b0;
        r_out    = 1'b0;
        con_in   = 1'b0;
        pc_out   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        alu_add  = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        pc_in    = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        if (!stall) begin
            case (state)
                S_T3: begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                end
                S_T4: begin
                    pc_out = 1'b1;
                    y_in   = 1'b1;
                end
                S_T5: begin
                    c_out   = 1'b1;
                    alu_add = 1'b1;
                    z_in    = 1'b1;
                end
                S_T6: begin
                    done     = 1'b1;
                    zlow_out = con_q;
                    pc_in    = con_q;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end else begin
            done = 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases with literal expectations,
// followed by randomized stimulus that is checked every cycle against a step-count model.
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, stall;
    logic [1:0]  ir_c2;
    logic [31:0] bus_contents;

    logic gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, con_q, busy, done;
    logic [15:0] taken_count;
    logic gra2, r_out2, con_in2, pc_out2, y_in2, c_out2, alu_add2, z_in2, zlow_out2, pc_in2, con_q2, busy2, done2;
    logic [1:0]  taken_count2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model: position inside the branch (0 idle, 1..4 = T3..T6), condition flag and count
    int          m_step;
    bit          m_con;
    int unsigned m_cnt;

    always #5 clock = ~clock;

    branch_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .clear(clear), .start(start), .stall(stall), .ir_c2(ir_c2),
        .bus_contents(bus_contents), .gra(gra), .r_out(r_out), .con_in(con_in),
        .pc_out(pc_out), .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .z_in(z_in),
        .zlow_out(zlow_out), .pc_in(pc_in), .con_q(con_q), .busy(busy), .done(done),
        .taken_count(taken_count)
    );

    branch_sequencer #(.CNT_W(2)) dut2 (
        .clock(clock), .clear(clear), .start(start), .stall(stall), .ir_c2(ir_c2),
        .bus_contents(bus_contents), .gra(gra2), .r_out(r_out2), .con_in(con_in2),
        .pc_out(pc_out2), .y_in(y_in2), .c_out(c_out2), .alu_add(alu_add2), .z_in(z_in2),
        .zlow_out(zlow_out2), .pc_in(pc_in2), .con_q(con_q2), .busy(busy2), .done(done2),
        .taken_count(taken_count2)
    );

    function automatic bit spec_cond(input logic [1:0] c, input logic [31:0] b);
        if (c == 2'b00) return (b == 32'd0);
        else if (c == 2'b01) return (b != 32'd0);
        else if (c == 2'b10) return !b[31];
        else return b[31];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0;
        m_con  = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance the model across one rising edge using the inputs present before it
    task automatic model_step();
        if (clear) begin
            model_reset();
        end else if (m_step == 0) begin
            if (start) m_step = 1;
        end else if (!stall) begin
            if (m_step == 1) m_con = spec_cond(ir_c2, bus_contents);
            if (m_step == 4) begin
                if (m_con) m_cnt++;
                m_step = 0;
            end else begin
                m_step++;
            end
        end
    endtask

    // Expected {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,zlow_out,pc_in,done}
    function automatic logic [10:0] exp_strobes();
        logic [10:0] v;
        v = 11'b0;
        if (!stall && !clear) begin
            case (m_step)
                1: v = 11'b11100000000;
                2: v = 11'b00011000000;
                3: v = 11'b00000111000;
                4: v = m_con ? 11'b00000000111 : 11'b00000000001;
                default: v = 11'b0;
            endcase
        end
        return v;
    endfunction

    // Per-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("strobes", {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, done},
                  exp_strobes());
            check("strobes_w2", {gra2, r_out2, con_in2, pc_out2, y_in2, c_out2, alu_add2, z_in2, zlow_out2,
                  pc_in2, done2}, exp_strobes());
            check("busy", busy, (m_step != 0));
            check("con_q", con_q, m_con);
            check("con_q_w2", con_q2, m_con);
            check("taken_count", taken_count, m_cnt);
            check("taken_count_w2", taken_count2, (m_cnt > 3) ? 3 : m_cnt);
            check("bus_drivers_exclusive", ($countones({r_out, pc_out, c_out, zlow_out}) <= 1), 1'b1);
        end
    end

    task automatic cyc(input bit s, input bit st, input logic [1:0] ir, input logic [31:0] b, input bit clr);
        @(posedge clock);
        model_step();
        #1;
        start = s;
        stall = st;
        ir_c2 = ir;
        bus_contents = b;
        clear = clr;
        if (clr) model_reset();
        @(negedge clock);
    endtask

    task automatic branch(input logic [1:0] ir, input logic [31:0] b, input bit exp_con,
                          input int exp_cnt, input int exp_cnt2);
        cyc(1'b1, 1'b0, ir, b, 1'b0);
        cyc(1'b0, 1'b0, ir, b, 1'b0);
        check("t3_gra", {gra, r_out, con_in}, 3'b111);
        cyc(1'b0, 1'b0, ir, b, 1'b0);
        check("t4_pc_out", {pc_out, y_in}, 2'b11);
        cyc(1'b0, 1'b0, ir, b, 1'b0);
        check("t5_z_in", {c_out, alu_add, z_in}, 3'b111);
        cyc(1'b0, 1'b0, ir, b, 1'b0);
        check("t6_done", done, 1'b1);
        check("t6_pc_in", {zlow_out, pc_in}, {exp_con, exp_con});
        check("t6_con_q", con_q, exp_con);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        check("after_busy", busy, 1'b0);
        check("after_count", taken_count, exp_cnt);
        check("after_count_w2", taken_count2, exp_cnt2);
    endtask

    initial begin
        int done_seen;
        clear = 1'b1; start = 1'b0; stall = 1'b0; ir_c2 = 2'b00; bus_contents = 32'd0;
        model_reset();
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        check("reset_state", {busy, done, con_q, pc_in, taken_count}, 20'd0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);

        branch(2'b00, 32'h00000000, 1'b1, 1, 1);
        branch(2'b01, 32'h00000000, 1'b0, 1, 1);
        branch(2'b10, 32'h80000000, 1'b0, 1, 1);
        branch(2'b11, 32'h80000000, 1'b1, 2, 2);
        branch(2'b10, 32'h00000001, 1'b1, 3, 3);
        branch(2'b01, 32'h00001234, 1'b1, 4, 3);

        // Three stall cycles in T4 with the bus changing underneath
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 32'hFFFF0000 + i, 1'b0);
            check("stall_quiet", {pc_out, y_in, busy, done}, 4'b0010);
            check("stall_con_q", con_q, 1'b1);
        end
        cyc(1'b0, 1'b0, 2'b00, 32'h5, 1'b0);
        check("stall_t4_resume", pc_out, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 32'h5, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'h5, 1'b0);
        check("stall_late_done", {done, pc_in}, 2'b11);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        check("stall_count", taken_count, 16'd5);

        // start during T4 must be ignored
        done_seen = 0;
        cyc(1'b1, 1'b0, 2'b01, 32'h5, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc((i == 1), 1'b0, 2'b01, 32'h5, 1'b0);
            if (done) done_seen++;
        end
        check("ignored_start_one_done", done_seen, 1);
        check("ignored_start_count", taken_count, 16'd6);

        // clear in T5 aborts, then start is accepted right after release
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b1);
        check("clear_outputs", {gra, pc_out, c_out, z_in, zlow_out, pc_in, done, busy, con_q, taken_count},
              25'd0);
        cyc(1'b1, 1'b0, 2'b01, 32'd0, 1'b0);
        check("clear_no_pc_in", pc_in, 1'b0);
        cyc(1'b0, 1'b0, 2'b01, 32'd0, 1'b0);
        check("restart_t3", {busy, gra}, 2'b11);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0);

        // Randomized traffic checked by the per-cycle compare
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'h80000000 | $urandom;
                2: b = 32'h7FFFFFFF & $urandom;
                default: b = $urandom;
            endcase
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), b,
                ($urandom_range(0, 199) == 0));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the taken-branch counter.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 clear  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  one-cycle pulse: a conditional-branch instruction is decoded; sampled only in IDLE.
REQ-005 stall  in  1  freeze request (memory or bus wait); sampled in every non-IDLE state.
REQ-006 ir_c2  in  2  condition field of the branch instruction; sampled only in T3.
REQ-007 bus_contents  in  32  value on the shared bus; sampled only in T3.
REQ-008 gra, r_out, con_in  out  1 each  select Ra onto the bus and enable condition capture.
REQ-009 pc_out, y_in  out  1 each  PC onto the bus, load Y.
REQ-010 c_out, alu_add, z_in  out  1 each  sign-extended constant onto the bus, ALU add, load Z.
REQ-011 zlow_out, pc_in  out  1 each  Z low word onto the bus, load PC.
REQ-012 con_q  out  1  registered branch-condition flag.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse in T6.
REQ-015 taken_count  out  CNT_W  number of taken branches since reset.

Function
REQ-016 States: IDLE, T3, T4, T5, T6 (one-hot or binary; encoding is not visible at the ports).
REQ-017 Transitions: IDLE->T3 on start=1; T3->T4->T5->T6->IDLE, one per cycle while stall=0.
REQ-018 With stall=1 in T3..T6, the state holds and all strobes (REQ-008..REQ-011, done) are driven 0; busy stays 1.
REQ-019 Strobes, registered outputs of the state, asserted only when stall=0: T3 gra, r_out, con_in; T4 pc_out, y_in; T5 c_out, alu_add, z_in; T6 done, plus zlow_out and pc_in only if con_q=1.
REQ-020 con_q loads on the rising edge that leaves T3 with stall=0 and holds at all other times, including while stalled and in IDLE.
REQ-021 Condition evaluation: ir_c2=00 -> con_q = (bus_contents==0).
REQ-022 Condition evaluation: ir_c2=01 -> con_q = (bus_contents!=0).
REQ-023 Condition evaluation: ir_c2=10 -> con_q = ~bus_contents[31].
REQ-024 Condition evaluation: ir_c2=11 -> con_q = bus_contents[31].
REQ-025 Latency: start at edge k -> T3 strobes in cycle k+1 -> done/pc_in in cycle k+4, with no stall; each stall cycle adds one cycle.
REQ-026 start asserted in any state other than IDLE, including T6, is ignored; there is no queueing.
REQ-027 taken_count increments by 1 on the edge leaving T6 when con_q=1, and saturates at 2^CNT_W-1 (no wrap).
REQ-028 At most one of r_out, pc_out, c_out, zlow_out is high in any cycle.

Reset
REQ-029 clear=1 forces, with no clock edge needed: state IDLE, every strobe 0, busy 0, done 0, con_q 0, taken_count 0.
REQ-030 clear asserted mid-sequence aborts the branch; pc_in is never asserted for the aborted instruction.
REQ-031 After clear deasserts, the first start is accepted on the next rising edge.

Verification
REQ-032 start, ir_c2=00, bus=0x00000000 -> T3..T6 in 4 consecutive cycles; con_q=1; zlow_out=pc_in=1 and done=1 in T6; taken_count=1.
REQ-033 ir_c2=01, bus=0x00000000 -> con_q=0; T6 shows done=1 with pc_in=0 and zlow_out=0; taken_count unchanged.
REQ-034 ir_c2=10, bus=0x80000000 -> con_q=0; ir_c2=11, bus=0x80000000 -> con_q=1; ir_c2=10, bus=0x00000001 -> con_q=1.
REQ-035 stall=1 for 3 cycles in T4 -> T4 held, all strobes 0, busy=1; done arrives 3 cycles late; changing bus during the stall leaves con_q unchanged.
REQ-036 clear pulse in T5 -> immediate IDLE, all outputs 0, no pc_in; a start pulse during T4 is ignored (one done only).
REQ-037 CNT_W=2, four taken branches -> taken_count 1,2,3,3 (saturation).
